alu_op_issuer: RTL and testbench
================================

// Module: alu_op_issuer
// PURPOSE
//  Request-side front end for alu32. Takes R-type funct + operands over a valid/ready handshake,
//  decodes funct into the 3-bit aluop, drives alu32 from registered operands and captures its result.
//  Implements the unused aluop 010 (mult) itself as a 32-cycle iterative unsigned multiply.
//  Returns the result (plus HI word for multu) over a valid/ready response channel.
// PARAMETERS
//  WIDTH    32  datapath width; must match alu32 (fixed 32)
//  FUNCT_W  6   funct field width
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  req_valid     in   1      request present
//  req_ready     out  1      issuer can accept; =1 only in IDLE
//  req_funct     in   6      R-type funct code
//  req_a, req_b  in   32     operands
//  alu_a, alu_b  out  32     registered operands to alu32
//  aluop         out  3      registered opcode to alu32
//  alu_result    in   32     alu32 combinational result
//  rsp_valid     out  1      response present
//  rsp_ready     in   1      consumer accepts response
//  rsp_lo        out  32     result (LO word for multu)
//  rsp_hi        out  32     HI word for multu, else 0
//  rsp_err       out  1      unsupported funct
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; alu_a/alu_b/aluop/rsp_lo/rsp_hi=0; rsp_valid=0; rsp_err=0.
//  Decode: 20h,21h->000 add; 22h,23h->001 sub; 19h->010 multu; 26h->011 xor; 24h->100 and;
//   25h->101 or; 2Ah->110 slt; 27h->111 nor; anything else -> error. No overflow trap on add/sub.
//  Handshake: accept on edge where req_valid & req_ready. Response held stable until rsp_valid & rsp_ready.
//  States: IDLE -> EXEC (ALU op) | MULT (multu) | RESP (error); EXEC -> RESP; MULT -> RESP after 32 steps;
//   RESP -> IDLE on rsp_ready.
//  Latency from accept edge T: ALU op rsp_valid at T+2; multu at T+33; error at T+1.
//  EXEC: alu_a/alu_b/aluop hold request values; alu_result captured into rsp_lo at EXEC exit; rsp_hi=0.
//  MULT: 5-bit step counter 0..31; shift-add over 64-bit product {hi,lo}; aluop=010 driven but alu_result ignored.
//  Error: rsp_lo=0, rsp_hi=0, rsp_err=1; rsp_err cleared on next accepted request.
//  No accept while busy: req_ready=0 in EXEC/MULT/RESP; at most one request in flight.
//  Response stall: RESP holds indefinitely while rsp_ready=0; all rsp_* stable.
//  RESP with rsp_ready=1: IDLE next cycle; earliest next accept one cycle later (no same-cycle bypass).
//  alu_a/alu_b/aluop keep last values in IDLE and RESP (no toggling).
//  Reset mid-operation: immediate return to IDLE, partial product discarded, rsp_valid drops.
//  Operands are unsigned for multu; 0xFFFFFFFF*0xFFFFFFFF must yield hi=FFFFFFFE, lo=00000001.
// STRUCTURE
//  Shared package alu_pkg: aluop encodings (ALU_ADD..ALU_NOR), funct constants, state encoding.
//  One sub-module: seq_mult32 (start/done, 32-cycle shift-add, 64-bit product out).
//  FSM, decode, operand/response registers stay in alu_op_issuer; alu32 instantiated outside.
// TESTING
//  funct=20h, a=5, b=7 -> rsp_lo=0000000C, rsp_hi=0, rsp_err=0, rsp_valid at T+2.
//  funct=2Ah, a=FFFFFFFF, b=1 -> rsp_lo=00000001 (signed slt); funct=27h, a=0, b=0 -> FFFFFFFF.
//  funct=19h, a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001 at T+33; req_ready=0 throughout.
//  funct=3Fh -> rsp_err=1, rsp_lo=0 at T+1; next valid request clears rsp_err.
//  rsp_ready held 0 for 10 cycles in RESP -> outputs stable, req_ready=0; release -> IDLE next cycle.
//  rst_n pulsed low at MULT step 15 -> rsp_valid=0, req_ready=1 immediately; new add returns correctly.

Source files
------------

// File: rtl/alu_op_issuer_pkg.sv
// alu_pkg: aluop encodings, R-type funct codes, issuer states and funct decode for alu_op_issuer.
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int FUNCT_W = 6;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_MULT = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_NOR  = 3'b111
  } aluop_e;
  localparam logic [FUNCT_W-1:0] F_ADD   = 6'h20;
  localparam logic [FUNCT_W-1:0] F_ADDU  = 6'h21;
  localparam logic [FUNCT_W-1:0] F_SUB   = 6'h22;
  localparam logic [FUNCT_W-1:0] F_SUBU  = 6'h23;
  localparam logic [FUNCT_W-1:0] F_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] F_XOR   = 6'h26;
  localparam logic [FUNCT_W-1:0] F_AND   = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR    = 6'h25;
  localparam logic [FUNCT_W-1:0] F_SLT   = 6'h2A;
  localparam logic [FUNCT_W-1:0] F_NOR   = 6'h27;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MULT, ST_RESP} state_e;
  typedef struct packed {
    logic   err;
    aluop_e op;
  } decode_t;
  function automatic decode_t decode(input logic [FUNCT_W-1:0] f);
    decode_t d;
    d.err = 1'b0;
    case (f)
      F_ADD, F_ADDU: d.op = ALU_ADD;
      F_SUB, F_SUBU: d.op = ALU_SUB;
      F_MULTU:       d.op = ALU_MULT;
      F_XOR:         d.op = ALU_XOR;
      F_AND:         d.op = ALU_AND;
      F_OR:          d.op = ALU_OR;
      F_SLT:         d.op = ALU_SLT;
      F_NOR:         d.op = ALU_NOR;
      default: begin
        d.op  = ALU_ADD;
        d.err = 1'b1;
      end
    endcase
    return d;
  endfunction
endpackage

// File: rtl/alu_op_issuer_if.sv
// alu_op_issuer_if: request and response valid/ready channels between a requester (master) and the issuer (slave).
interface alu_op_issuer_if;
  import alu_pkg::*;
  logic               req_valid;
  logic               req_ready;
  logic [FUNCT_W-1:0] req_funct;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_lo;
  logic [WIDTH-1:0]   rsp_hi;
  logic               rsp_err;
  modport master (
    output req_valid, req_funct, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err
  );
  modport slave (
    input  req_valid, req_funct, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err
  );
endinterface

// File: rtl/alu_op_issuer_seq_mult32.sv
// seq_mult32: unsigned 32x32 shift-add multiplier, one step per cycle for 32 cycles.
// product_o is the combinational result of the current step, so it is final while done_o is high.
module seq_mult32
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  logic               busy_q;
  logic [4:0]         cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0]     sum;
  // {hi, lo} starts as {0, multiplier}; each step adds the multiplicand to hi on lo[0] and shifts right
  always_comb begin
    sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    p_d = {sum, p_q[WIDTH-1:1]};
  end
  assign product_o = p_d;
  assign done_o = busy_q && (cnt_q == 5'd31);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      p_q     <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      mcand_q <= a_i;
      p_q     <= {{WIDTH{1'b0}}, b_i};
    end else if (busy_q) begin
      p_q    <= p_d;
      cnt_q  <= cnt_q + 5'd1;
      busy_q <= !done_o;
    end
endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: decodes R-type funct, drives an external alu32 from registered operands, runs multu
// on an internal sequential multiplier and returns results over a valid/ready response channel.
module alu_op_issuer
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  alu_op_issuer_if.slave   bus,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       aluop_o,
  input  logic [WIDTH-1:0] alu_result_i
);
  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, lo_q, hi_q;
  aluop_e             op_q;
  logic               err_q;
  decode_t            dec;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  assign dec       = decode(bus.req_funct);
  assign mul_start = (state_q == ST_IDLE) && bus.req_valid && !dec.err && (dec.op == ALU_MULT);
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_lo    = lo_q;
  assign bus.rsp_hi    = hi_q;
  assign bus.rsp_err   = err_q;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign aluop_o       = op_q;
  seq_mult32 u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (bus.req_a),
    .b_i       (bus.req_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );
  // Unsupported functs skip the ALU and leave the operand registers untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADD;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else
      case (state_q)
        ST_IDLE: if (bus.req_valid) begin
          err_q <= dec.err;
          if (dec.err) begin
            lo_q    <= '0;
            hi_q    <= '0;
            state_q <= ST_RESP;
          end else begin
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            op_q    <= dec.op;
            state_q <= (dec.op == ALU_MULT) ? ST_MULT : ST_EXEC;
          end
        end
        ST_EXEC: begin
          lo_q    <= alu_result_i;
          hi_q    <= '0;
          state_q <= ST_RESP;
        end
        ST_MULT: if (mul_done) begin
          {hi_q, lo_q} <= mul_prod;
          state_q      <= ST_RESP;
        end
        default: if (bus.rsp_ready) state_q <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: randomized and directed requests scored against a funct-level reference model.
module tb_alu_op_issuer;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_op_issuer_if bus ();
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  aluop;
  alu_op_issuer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .aluop_o      (aluop),
    .alu_result_i (alu_result)
  );
  // Stand-in for the external alu32
  always_comb begin
    alu_result = 32'hDEADBEEF;
    case (aluop)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd3: alu_result = alu_a ^ alu_b;
      3'd4: alu_result = alu_a & alu_b;
      3'd5: alu_result = alu_a | alu_b;
      3'd6: alu_result = 32'($signed(alu_a) < $signed(alu_b));
      3'd7: alu_result = ~(alu_a | alu_b);
      default: ;
    endcase
  end
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];
  exp_t em;
  int checks = 0, errors = 0, cyc = 0, rdy_mode = 0;
  logic seen = 1'b0;
  logic [31:0] h_lo, h_hi;
  logic h_err;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e.lo = '0; e.hi = '0; e.err = 1'b0; e.lat = 2; e.acc = 0;
    case (f)
      6'h20, 6'h21: e.lo = a + b;
      6'h22, 6'h23: e.lo = a - b;
      6'h19: begin
        p = {32'd0, a} * {32'd0, b};
        e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
      6'h26: e.lo = a ^ b;
      6'h24: e.lo = a & b;
      6'h25: e.lo = a | b;
      6'h2A: e.lo = (int'($signed(a)) < int'($signed(b))) ? 32'd1 : 32'd0;
      6'h27: e.lo = ~(a | b);
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction
  // Monitor: score each new response, then require it to stay stable until taken
  always @(negedge clk) if (rst_n) begin
    if (bus.rsp_valid && !seen) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got lo=%h with no request outstanding", bus.rsp_lo);
      end else begin
        em = q.pop_front();
        chk("rsp_lo", bus.rsp_lo, em.lo);
        chk("rsp_hi", bus.rsp_hi, em.hi);
        chk("rsp_err", bus.rsp_err, em.err);
        chk("latency", cyc - em.acc + 1, em.lat);
      end
      seen = 1'b1; h_lo = bus.rsp_lo; h_hi = bus.rsp_hi; h_err = bus.rsp_err;
    end else if (bus.rsp_valid) begin
      chk("hold_lo", bus.rsp_lo, h_lo);
      chk("hold_hi", bus.rsp_hi, h_hi);
      chk("hold_err", bus.rsp_err, h_err);
      chk("hold_req_ready", bus.req_ready, 0);
    end else begin
      seen = 1'b0;
      if (q.size() != 0) chk("busy_req_ready", bus.req_ready, 0);
    end
  end
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.rsp_ready = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end
  task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    exp_t e;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_funct = f; bus.req_a = a; bus.req_b = b;
    @(negedge clk);
    while (!bus.req_ready && n < 300) begin n++; @(negedge clk); end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=0 after %0d cycles, required 1", n);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e = model(f, a, b);
    e.acc = cyc;
    q.push_back(e);
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin n++; @(negedge clk); end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses missing, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic wait_rsp_valid();
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 100) begin n++; @(negedge clk); end
    chk("rsp_valid_seen", bus.rsp_valid, 1);
  endtask
  initial begin
    logic [5:0] fl [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h19, 6'h26, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h3F, 6'h00};
    logic [31:0] edge_v [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] ra, rb;
    bus.req_valid = 1'b0; bus.req_funct = '0; bus.req_a = '0; bus.req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_aluop", aluop, 0);
    chk("rst_rsp_lo", bus.rsp_lo, 0);
    chk("rst_rsp_hi", bus.rsp_hi, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(6'h20, 32'd5, 32'd7);
    send(6'h2A, 32'hFFFF_FFFF, 32'd1);
    send(6'h27, 32'd0, 32'd0);
    send(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(6'h3F, 32'h1234, 32'h5678);
    send(6'h22, 32'd3, 32'd10);
    drain();
    rdy_mode = 1;
    send(6'h25, 32'h0F0F_0000, 32'h0000_00F0);
    wait_rsp_valid();
    repeat (10) begin
      @(negedge clk);
      chk("stall_rsp_valid", bus.rsp_valid, 1);
    end
    rdy_mode = 2;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("release_rsp_valid", bus.rsp_valid, 0);
    chk("release_req_ready", bus.req_ready, 1);
    rdy_mode = 0;
    send(6'h19, 32'h0001_0003, 32'h0000_0101);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_req_ready", bus.req_ready, 1);
    chk("midrst_rsp_hi", bus.rsp_hi, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(6'h21, 32'hFFFF_FFFF, 32'd2);
    drain();
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      send(fl[$urandom_range(0, 11)], ra, rb);
    end
    drain();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end
endmodule
